// File: rtl/audio_mix_pkg.sv
// Shared types and helpers for the N-channel stereo mixer.
//   mix_state_t : mixer sequencing states
//   calc_accw   : accumulator width for a given input width / channel count
//   sat_s       : clamp a wide signed value into a signed field of 'width' bits
package audio_mix_pkg;

  typedef enum logic [1:0] {StIdle, StMac, StSat, StOut} mix_state_t;

  // Width used for saturation arithmetic; wide enough for any legal accumulator.
  localparam int unsigned SatW = 64;

  // A product is < 4x full scale (Q2 gain) -> IW+2, summing NCH adds clog2(NCH), plus one guard bit.
  function automatic int unsigned calc_accw(input int unsigned iw, input int unsigned nch);
    return iw + 2 + $clog2(nch) + 1;
  endfunction

  function automatic logic signed [SatW-1:0] sat_s(input logic signed [SatW-1:0] value,
                                                   input int unsigned width);
    logic signed [SatW-1:0] hi;
    logic signed [SatW-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (value > hi) begin
      return hi;
    end else if (value < lo) begin
      return lo;
    end
    return value;
  endfunction

endpackage

// File: rtl/audio_softmute_ramp.sv
// Click-free soft-mute: a ramp counter that steps once per output sample toward
// 0 (mute) or full scale 2**RAMP_W (unmuted), and scales both channels by it.
//   clk, reset_n : clock, async active-low reset (ramp starts at 0 -> fade-in)
//   mute         : target select, 1 = fade to silence
//   step         : advance the ramp by one toward its target
//   in_l, in_r   : signed samples to scale
//   out_l, out_r : (in * ramp) >>> RAMP_W, combinational
module audio_softmute_ramp #(
  parameter int unsigned OW     = 16,
  parameter int unsigned RAMP_W = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 mute,
  input  logic                 step,
  input  logic signed [OW-1:0] in_l,
  input  logic signed [OW-1:0] in_r,
  output logic signed [OW-1:0] out_l,
  output logic signed [OW-1:0] out_r
);

  localparam int unsigned PW = OW + RAMP_W + 2;
  localparam logic [RAMP_W:0] RampFull = {1'b1, {RAMP_W{1'b0}}};

  logic [RAMP_W:0] ramp_q, ramp_d;

  always_comb begin
    ramp_d = ramp_q;
    if (step) begin
      if (mute) begin
        if (ramp_q != '0) ramp_d = ramp_q - 1'b1;
      end else begin
        if (ramp_q != RampFull) ramp_d = ramp_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ramp_q <= '0;
    end else begin
      ramp_q <= ramp_d;
    end
  end

  // Ramp is zero-extended so it multiplies as a non-negative signed value;
  // at full scale the shift exactly undoes the multiply.
  logic signed [PW-1:0] ramp_s, ext_l, ext_r, prod_l, prod_r;

  always_comb begin
    ramp_s = {{(PW - RAMP_W - 1){1'b0}}, ramp_q};
    ext_l  = PW'(in_l);
    ext_r  = PW'(in_r);
    prod_l = ext_l * ramp_s;
    prod_r = ext_r * ramp_s;
    out_l  = OW'(prod_l >>> RAMP_W);
    out_r  = OW'(prod_r >>> RAMP_W);
  end

endmodule

// File: rtl/audio_mixer_n.sv
// N-channel stereo mixer with per-channel gain, saturation and soft mute.
//   clk, reset_n        : clock, async active-low reset
//   ch_valid[NCH]       : per-channel sample strobe, latches ch_in_l/r into the hold regs
//   ch_in_l/ch_in_r     : packed signed samples, channel k at [k*IW +: IW]
//   ch_gain             : packed unsigned Q2.(GW-2) gains, channel k at [k*GW +: GW]
//   ch_en[NCH]          : channel enable
//   mute                : soft-mute target
//   out_tick            : output-rate strobe; starts a mix when idle
//   out_l/out_r         : mixed output, held between updates
//   out_valid, clip     : 1-cycle pulses on output update (clip if either side saturated)
//   overrun             : 1-cycle pulse (registered) when out_tick arrives while busy
module audio_mixer_n
  import audio_mix_pkg::*;
#(
  parameter int unsigned NCH    = 4,
  parameter int unsigned IW     = 16,
  parameter int unsigned OW     = 16,
  parameter int unsigned GW     = 8,
  parameter int unsigned RAMP_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    ch_valid,
  input  logic [NCH*IW-1:0] ch_in_l,
  input  logic [NCH*IW-1:0] ch_in_r,
  input  logic [NCH*GW-1:0] ch_gain,
  input  logic [NCH-1:0]    ch_en,
  input  logic              mute,
  input  logic              out_tick,
  output logic [OW-1:0]     out_l,
  output logic [OW-1:0]     out_r,
  output logic              out_valid,
  output logic              clip,
  output logic              overrun
);

  localparam int unsigned ACCW = calc_accw(IW, NCH);
  localparam int unsigned IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned MW   = ACCW + GW;

  mix_state_t state_q, state_d;

  logic signed [IW-1:0]   hold_l_q [NCH];
  logic signed [IW-1:0]   hold_r_q [NCH];
  logic signed [IW-1:0]   snap_l_q [NCH];
  logic signed [IW-1:0]   snap_r_q [NCH];
  logic [IDXW-1:0]        idx_q;
  logic signed [ACCW-1:0] acc_l_q, acc_r_q;
  logic signed [OW-1:0]   sat_l_q, sat_r_q;
  logic                   clip_q;
  logic                   snap_load;

  assign snap_load = (state_q == StIdle) && out_tick;

  // Hold regs follow the strobes at all times; the snapshot is only taken at the
  // start of a mix, with a same-cycle strobe bypassing the hold reg.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NCH; k++) begin
        hold_l_q[k] <= '0;
        hold_r_q[k] <= '0;
        snap_l_q[k] <= '0;
        snap_r_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (ch_valid[k]) begin
          hold_l_q[k] <= ch_in_l[k*IW +: IW];
          hold_r_q[k] <= ch_in_r[k*IW +: IW];
        end
        if (snap_load) begin
          snap_l_q[k] <= ch_valid[k] ? ch_in_l[k*IW +: IW] : hold_l_q[k];
          snap_r_q[k] <= ch_valid[k] ? ch_in_r[k*IW +: IW] : hold_r_q[k];
        end
      end
    end
  end

  // Shared per-side multiplier: (sample * gain) >>> (GW-2), sign-extended to ACCW.
  function automatic logic signed [ACCW-1:0] scale(input logic signed [IW-1:0] s,
                                                   input logic [GW-1:0] g);
    logic signed [MW-1:0] se, ge, p;
    se = MW'(s);
    ge = {{(MW - GW){1'b0}}, g};
    p  = se * ge;
    return ACCW'(p >>> (GW - 2));
  endfunction

  logic [GW-1:0]          cur_gain;
  logic signed [ACCW-1:0] term_l, term_r;

  always_comb begin
    cur_gain = ch_gain[idx_q*GW +: GW];
    term_l   = '0;
    term_r   = '0;
    if (ch_en[idx_q]) begin
      term_l = scale(snap_l_q[idx_q], cur_gain);
      term_r = scale(snap_r_q[idx_q], cur_gain);
    end
  end

  logic signed [SatW-1:0] acc_l_w, acc_r_w, sat_l_w, sat_r_w;

  always_comb begin
    acc_l_w = SatW'(acc_l_q);
    acc_r_w = SatW'(acc_r_q);
    sat_l_w = sat_s(acc_l_w, OW);
    sat_r_w = sat_s(acc_r_w, OW);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (out_tick) state_d = StMac;
      StMac:   if (idx_q == IDXW'(NCH - 1)) state_d = StSat;
      StSat:   state_d = StOut;
      StOut:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  logic signed [OW-1:0] ramped_l, ramped_r;

  audio_softmute_ramp #(
    .OW     (OW),
    .RAMP_W (RAMP_W)
  ) u_ramp (
    .clk     (clk),
    .reset_n (reset_n),
    .mute    (mute),
    .step    (state_q == StOut),
    .in_l    (sat_l_q),
    .in_r    (sat_r_q),
    .out_l   (ramped_l),
    .out_r   (ramped_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      sat_l_q   <= '0;
      sat_r_q   <= '0;
      clip_q    <= 1'b0;
      out_l     <= '0;
      out_r     <= '0;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_valid <= 1'b0;
      clip      <= 1'b0;
      overrun   <= out_tick && (state_q != StIdle);
      case (state_q)
        StIdle: begin
          if (out_tick) begin
            idx_q   <= '0;
            acc_l_q <= '0;
            acc_r_q <= '0;
          end
        end
        StMac: begin
          acc_l_q <= acc_l_q + term_l;
          acc_r_q <= acc_r_q + term_r;
          idx_q   <= idx_q + 1'b1;
        end
        StSat: begin
          sat_l_q <= OW'(sat_l_w);
          sat_r_q <= OW'(sat_r_w);
          clip_q  <= (sat_l_w != acc_l_w) || (sat_r_w != acc_r_w);
        end
        StOut: begin
          out_l     <= ramped_l;
          out_r     <= ramped_r;
          out_valid <= 1'b1;
          clip      <= clip_q;
        end
        default: ;
      endcase
    end
  end

endmodule
